mem_port_arbiter: RTL and testbench

- Shares the single unified instruction/data memory of the multicycle core between two requesters: the core's memory port and a program-loader/debug port.
- Sits between the core datapath's address/write-data path (driven by the control unit's adrsource/memwrite sequencing) and the synchronous-read memory.
- Serializes one transaction at a time with a req/ack handshake and round-robin arbitration on contention.

---
 rtl/mem_port_arbiter.sv | 114 +++++++++++
 tb/tb_mem_port_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the core's unified synchronous-read memory.
// One transaction at a time: IDLE -> ISSUE -> CAPTURE -> ACK, round-robin on contention.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_ack,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic [DATA_W-1:0] l_rdata,
  output logic              l_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, ACK} state_t;

  state_t            state, state_nxt;
  logic              last_grant;
  logic              grant;
  logic              start;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state <= state_nxt;
      if (start) last_grant <= grant;
    end
  end

  // Contention goes to whoever did not win last; a lone request wins outright.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    grant     = last_grant;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    c_ack     = 1'b0;
    l_ack     = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (c_req || l_req) begin
          start     = 1'b1;
          grant     = (c_req && l_req) ? ~last_grant : l_req;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        mem_en    = 1'b1;
        mem_we    = lat_we;
        mem_addr  = lat_addr;
        mem_wdata = lat_wdata;
        state_nxt = CAPTURE;
      end
      CAPTURE: begin
        mem_addr  = lat_addr;
        mem_wdata = lat_wdata;
        state_nxt = ACK;
      end
      ACK: begin
        mem_addr  = lat_addr;
        mem_wdata = lat_wdata;
        c_ack     = ~last_grant;
        l_ack     = last_grant;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Payload is only observed outside IDLE, so it needs no reset.
  always_ff @(posedge clk) begin
    if (start) begin
      lat_we    <= grant ? l_we    : c_we;
      lat_addr  <= grant ? l_addr  : c_addr;
      lat_wdata <= grant ? l_wdata : c_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_rdata <= '0;
      l_rdata <= '0;
    end else if (state == CAPTURE && !lat_we) begin
      if (last_grant) l_rdata <= mem_rdata;
      else            c_rdata <= mem_rdata;
    end
  end

  assign owner = last_grant;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a cycle-offset reference model and a memory stub.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        c_req = 1'b0, c_we = 1'b0, l_req = 1'b0, l_we = 1'b0;
  logic [31:0] c_addr = '0, c_wdata = '0, l_addr = '0, l_wdata = '0;
  logic [31:0] c_rdata, l_rdata, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        c_ack, l_ack, mem_en, mem_we, busy, owner;

  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_rdata(c_rdata), .c_ack(c_ack),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_rdata(l_rdata), .l_ack(l_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory stub.
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[7:0]];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a transaction granted at edge g is in issue/capture/ack
  // during the periods after edges g, g+1, g+2; a new grant is possible from edge g+4.
  int          ecount = 0;
  int          g_edge = 0;
  bit          have = 1'b0;
  bit          m_own = 1'b0, m_we = 1'b0, m_last = 1'b1;
  logic [31:0] m_addr = '0, m_wdata = '0, m_crd = '0, m_lrd = '0;
  logic [31:0] ref_mem [256];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      have   = 1'b0;
      m_last = 1'b1;
      m_crd  = '0;
      m_lrd  = '0;
    end else begin
      ecount++;
      if (have && ecount - g_edge == 1 && m_we) ref_mem[m_addr[7:0]] = m_wdata;
      if (have && ecount - g_edge == 2 && !m_we) begin
        if (m_own) m_lrd = ref_mem[m_addr[7:0]];
        else       m_crd = ref_mem[m_addr[7:0]];
      end
      if ((!have || ecount - g_edge >= 4) && (c_req || l_req)) begin
        m_own   = (c_req && l_req) ? !m_last : l_req;
        m_we    = m_own ? l_we    : c_we;
        m_addr  = m_own ? l_addr  : c_addr;
        m_wdata = m_own ? l_wdata : c_wdata;
        m_last  = m_own;
        g_edge  = ecount;
        have    = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    int  p;
    bit  act;
    p   = ecount - g_edge + 1;
    act = have && p >= 1 && p <= 3;
    chk1("busy",      busy,   act);
    chk1("mem_en",    mem_en, act && p == 1);
    chk1("mem_we",    mem_we, act && p == 1 && m_we);
    chk("mem_addr",   mem_addr,  act ? m_addr  : 32'h0);
    chk("mem_wdata",  mem_wdata, act ? m_wdata : 32'h0);
    chk1("c_ack",     c_ack,  act && p == 3 && !m_own);
    chk1("l_ack",     l_ack,  act && p == 3 && m_own);
    chk1("owner",     owner,  m_last);
    chk("c_rdata",    c_rdata, m_crd);
    chk("l_rdata",    l_rdata, m_lrd);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One uncontended transaction from an idle start, with literal expectations.
  task automatic txn(input bit ld, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata, input bit change_addr);
    if (ld) begin l_req = 1'b1; l_we = we; l_addr = addr; l_wdata = wdata; end
    else    begin c_req = 1'b1; c_we = we; c_addr = addr; c_wdata = wdata; end
    step();
    if (change_addr) c_addr = 32'h0000_0020;
    chk1("issue_en", mem_en, 1'b1);
    chk1("issue_we", mem_we, we);
    chk("issue_addr", mem_addr, addr);
    if (we) chk("issue_wdata", mem_wdata, wdata);
    step();
    chk1("capture_en", mem_en, 1'b0);
    step();
    chk1("ack_owner", ld ? l_ack : c_ack, 1'b1);
    chk1("ack_other", ld ? c_ack : l_ack, 1'b0);
    chk("ack_rdata", ld ? l_rdata : c_rdata, exp_rdata);
    step();
    c_req = 1'b0; l_req = 1'b0;
    chk1("post_ack", c_ack | l_ack, 1'b0);
  endtask

  initial begin
    int order [4];
    int at [4];
    int n_ack;
    int cyc;
    for (int i = 0; i < 256; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    mem[8'h10] = 32'hDEAD_BEEF; ref_mem[8'h10] = 32'hDEAD_BEEF;
    mem[8'h20] = 32'hCAFE_F00D; ref_mem[8'h20] = 32'hCAFE_F00D;

    #1 reset = 1'b1;
    #2;
    chk1("rst_en", mem_en, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_owner", owner, 1'b1);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_crdata", c_rdata, 32'h0);
    @(posedge clk); #1 reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk1("idle_en", mem_en, 1'b0);
    end

    txn(1'b0, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0);
    chk("core_rd_lrdata", l_rdata, 32'h0);
    txn(1'b1, 1'b1, 32'h0000_0040, 32'h1234_5678, 32'h0, 1'b0);
    txn(1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'h1234_5678, 1'b0);
    chk("ld_rd_crdata", c_rdata, 32'hDEAD_BEEF);
    txn(1'b0, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b1);

    step();
    #3 reset = 1'b1;
    #1;
    chk("midrst_crdata", c_rdata, 32'h0);
    chk("midrst_lrdata", l_rdata, 32'h0);
    chk1("midrst_owner", owner, 1'b1);
    @(posedge clk); #1 reset = 1'b0;
    step();

    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h0000_0010;
    l_req = 1'b1; l_we = 1'b0; l_addr = 32'h0000_0040;
    n_ack = 0; cyc = 0;
    for (int k = 0; k < 40 && n_ack < 4; k++) begin
      step();
      cyc++;
      if (c_ack && l_ack) chk1("both_ack", 1'b1, 1'b0);
      if (c_ack)      begin order[n_ack] = 0; at[n_ack] = cyc; n_ack++; end
      else if (l_ack) begin order[n_ack] = 1; at[n_ack] = cyc; n_ack++; end
      if (n_ack == 4) begin c_req = 1'b0; l_req = 1'b0; end
    end
    c_req = 1'b0; l_req = 1'b0;
    chk("cont_nack", n_ack, 32'd4);
    if (n_ack > 0) chk("cont_first_at", at[0], 32'd3);
    for (int i = 0; i < n_ack; i++) begin
      chk("cont_order", order[i], i % 2);
      if (i > 0) chk("cont_gap", at[i] - at[i-1], 32'd4);
    end
    chk("cont_crdata", c_rdata, 32'hDEAD_BEEF);
    chk("cont_lrdata", l_rdata, 32'h1234_5678);
    step();

    c_req = 1'b1; c_we = 1'b1; c_addr = 32'h0000_0080; c_wdata = 32'h1111_1111;
    step();
    chk1("abort_issue_en", mem_en, 1'b1);
    chk1("abort_issue_we", mem_we, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk1("abort_en", mem_en, 1'b0);
    chk1("abort_we", mem_we, 1'b0);
    c_req = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk1("abort_no_ack", c_ack, 1'b0);
    end
    txn(1'b0, 1'b1, 32'h0000_0080, 32'hA5A5_A5A5, 32'h0, 1'b0);
    txn(1'b0, 1'b0, 32'h0000_0080, 32'h0, 32'hA5A5_A5A5, 1'b0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
